// File: rtl/lemming_crowd.sv
// lemming_crowd: NUM_LEMMINGS independent lemming FSMs that walk, jump, dig, fall and
// optionally splat. Define LEMMING_SPLAT_EN to enable fall counting and the SPLAT state.
module lemming_crowd #(
    parameter int NUM_LEMMINGS = 4,
    parameter int FALL_LIMIT   = 20,
    parameter int JUMP_CYCLES  = 2
) (
    input  logic                                  clk,
    input  logic                                  areset,
    input  logic [NUM_LEMMINGS-1:0]               bump_left,
    input  logic [NUM_LEMMINGS-1:0]               bump_right,
    input  logic [NUM_LEMMINGS-1:0]               small_bump_left,
    input  logic [NUM_LEMMINGS-1:0]               small_bump_right,
    input  logic [NUM_LEMMINGS-1:0]               ground,
    input  logic [NUM_LEMMINGS-1:0]               dig,
    output logic [NUM_LEMMINGS-1:0]               walk_left,
    output logic [NUM_LEMMINGS-1:0]               walk_right,
    output logic [NUM_LEMMINGS-1:0]               aah,
    output logic [NUM_LEMMINGS-1:0]               digging,
    output logic [NUM_LEMMINGS-1:0]               jumping,
    output logic [NUM_LEMMINGS-1:0]               splat,
    output logic [$clog2(NUM_LEMMINGS+1)-1:0]     alive_count,
    output logic                                  all_dead
);
    localparam int CNT_MAX = (FALL_LIMIT > JUMP_CYCLES) ? FALL_LIMIT : JUMP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int AC_W    = $clog2(NUM_LEMMINGS + 1);
    localparam logic [CNT_W-1:0] JUMP_LAST = CNT_W'(JUMP_CYCLES - 1);
`ifdef LEMMING_SPLAT_EN
    localparam logic [CNT_W-1:0] FALL_SAT  = CNT_W'(FALL_LIMIT);
`endif

    typedef enum logic [3:0] {
        WALK_L, WALK_R, FALL_L, FALL_R, DIG_L, DIG_R, JUMP_L, JUMP_R, SPLAT
    } state_t;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LEMMINGS; gi++) begin : g_lane
            state_t           state_reg;
            logic [CNT_W-1:0] cnt_reg;
            logic             heading_left;
            logic             big_ahead;
            logic             small_ahead;
            state_t           walk_state;
            state_t           fall_state;
            state_t           dig_state;
            state_t           jump_state;

            // Direction the lane will resume walking in, shared by all non-dead states.
            assign heading_left = (state_reg == WALK_L) || (state_reg == FALL_L) ||
                                  (state_reg == DIG_L)  || (state_reg == JUMP_L);
            assign big_ahead    = heading_left ? bump_left[gi] : bump_right[gi];
            assign small_ahead  = heading_left ? small_bump_left[gi] : small_bump_right[gi];
            assign walk_state   = heading_left ? WALK_L : WALK_R;
            assign fall_state   = heading_left ? FALL_L : FALL_R;
            assign dig_state    = heading_left ? DIG_L  : DIG_R;
            assign jump_state   = heading_left ? JUMP_L : JUMP_R;

            always_ff @(posedge clk or negedge areset) begin
                if (!areset) begin
                    state_reg <= WALK_L;
                    cnt_reg   <= '0;
                end else begin
                    case (state_reg)
                        WALK_L, WALK_R: begin
                            if (!ground[gi]) begin
                                state_reg <= fall_state;
                                cnt_reg   <= '0;
                            end else if (dig[gi]) begin
                                state_reg <= dig_state;
                            end else if (big_ahead) begin
                                state_reg <= heading_left ? WALK_R : WALK_L;
                            end else if (small_ahead) begin
                                state_reg <= jump_state;
                                cnt_reg   <= '0;
                            end
                        end
                        DIG_L, DIG_R: begin
                            if (!ground[gi]) begin
                                state_reg <= fall_state;
                                cnt_reg   <= '0;
                            end
                        end
                        JUMP_L, JUMP_R: begin
                            if (cnt_reg == JUMP_LAST) begin
                                if (ground[gi]) begin
                                    state_reg <= walk_state;
                                end else begin
                                    state_reg <= fall_state;
                                    cnt_reg   <= '0;
                                end
                            end else begin
                                cnt_reg <= cnt_reg + CNT_W'(1);
                            end
                        end
                        FALL_L, FALL_R: begin
                            if (!ground[gi]) begin
`ifdef LEMMING_SPLAT_EN
                                // Saturate so arbitrarily long falls still splat.
                                if (cnt_reg < FALL_SAT) cnt_reg <= cnt_reg + CNT_W'(1);
`endif
                            end
`ifdef LEMMING_SPLAT_EN
                            else if (cnt_reg >= FALL_SAT) begin
                                state_reg <= SPLAT;
                            end
`endif
                            else begin
                                state_reg <= walk_state;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            assign walk_left[gi]  = (state_reg == WALK_L);
            assign walk_right[gi] = (state_reg == WALK_R);
            assign aah[gi]        = (state_reg == FALL_L) || (state_reg == FALL_R);
            assign digging[gi]    = (state_reg == DIG_L)  || (state_reg == DIG_R);
            assign jumping[gi]    = (state_reg == JUMP_L) || (state_reg == JUMP_R);
`ifdef LEMMING_SPLAT_EN
            assign splat[gi]      = (state_reg == SPLAT);
`else
            assign splat[gi]      = 1'b0;
`endif
        end
    endgenerate

`ifdef LEMMING_SPLAT_EN
    logic [AC_W-1:0] alive_sum;

    always_comb begin
        alive_sum = '0;
        for (int i = 0; i < NUM_LEMMINGS; i++) begin
            if (!splat[i]) alive_sum = alive_sum + AC_W'(1);
        end
    end

    assign alive_count = alive_sum;
    assign all_dead    = (alive_sum == '0);
`else
    assign alive_count = AC_W'(NUM_LEMMINGS);
    assign all_dead    = 1'b0;
`endif

endmodule

// File: tb/tb_lemming_crowd.sv
// Directed + randomized bench for lemming_crowd against a lane-level behavioural model.
module tb_lemming_crowd;
    localparam int N  = 4;
    localparam int FL = 20;
    localparam int JC = 2;
    localparam int AW = $clog2(N + 1);
`ifdef LEMMING_SPLAT_EN
    localparam bit SPLAT_EN = 1'b1;
`else
    localparam bit SPLAT_EN = 1'b0;
`endif
    localparam int A_WALK = 0, A_FALL = 1, A_DIG = 2, A_JUMP = 3, A_DEAD = 4;

    logic          clk = 1'b0;
    logic          areset = 1'b0;
    logic [N-1:0]  bump_left = '0, bump_right = '0;
    logic [N-1:0]  small_bump_left = '0, small_bump_right = '0;
    logic [N-1:0]  ground = '1, dig = '0;
    logic [N-1:0]  walk_left, walk_right, aah, digging, jumping, splat;
    logic [AW-1:0] alive_count;
    logic          all_dead;

    int checks = 0;
    int failures = 0;

    // Model: activity, heading (0 = left), low edges seen in the current fall, jump cycles shown.
    int act [N];
    int dir [N];
    int fall_len [N];
    int air [N];
    int low_run [N];

    lemming_crowd #(.NUM_LEMMINGS(N), .FALL_LIMIT(FL), .JUMP_CYCLES(JC)) dut (
        .clk(clk), .areset(areset),
        .bump_left(bump_left), .bump_right(bump_right),
        .small_bump_left(small_bump_left), .small_bump_right(small_bump_right),
        .ground(ground), .dig(dig),
        .walk_left(walk_left), .walk_right(walk_right), .aah(aah),
        .digging(digging), .jumping(jumping), .splat(splat),
        .alive_count(alive_count), .all_dead(all_dead)
    );

    always #5 clk = ~clk;

    task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            act[i] = A_WALK; dir[i] = 0; fall_len[i] = 0; air[i] = 0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < N; i++) begin
            case (act[i])
                A_WALK: begin
                    if (!ground[i]) begin act[i] = A_FALL; fall_len[i] = 1; end
                    else if (dig[i]) act[i] = A_DIG;
                    else if ((dir[i] == 0) ? bump_left[i] : bump_right[i]) dir[i] = 1 - dir[i];
                    else if ((dir[i] == 0) ? small_bump_left[i] : small_bump_right[i]) begin
                        act[i] = A_JUMP; air[i] = 1;
                    end
                end
                A_DIG: if (!ground[i]) begin act[i] = A_FALL; fall_len[i] = 1; end
                A_JUMP: begin
                    if (air[i] < JC) air[i]++;
                    else if (ground[i]) act[i] = A_WALK;
                    else begin act[i] = A_FALL; fall_len[i] = 1; end
                end
                A_FALL: begin
                    if (!ground[i]) fall_len[i]++;
                    else if (SPLAT_EN && fall_len[i] > FL) act[i] = A_DEAD;
                    else act[i] = A_WALK;
                end
                default: ;
            endcase
        end
    endtask

    task automatic check_all(input string tag);
        logic [N-1:0] e_wl, e_wr, e_aah, e_dig, e_jmp, e_spl;
        int alive;
        alive = 0;
        for (int i = 0; i < N; i++) begin
            e_wl[i]  = (act[i] == A_WALK) && (dir[i] == 0);
            e_wr[i]  = (act[i] == A_WALK) && (dir[i] == 1);
            e_aah[i] = (act[i] == A_FALL);
            e_dig[i] = (act[i] == A_DIG);
            e_jmp[i] = (act[i] == A_JUMP);
            e_spl[i] = (act[i] == A_DEAD);
            if (act[i] != A_DEAD) alive++;
        end
        expect_eq({tag, ".walk_left"},   32'(walk_left),   32'(e_wl));
        expect_eq({tag, ".walk_right"},  32'(walk_right),  32'(e_wr));
        expect_eq({tag, ".aah"},         32'(aah),         32'(e_aah));
        expect_eq({tag, ".digging"},     32'(digging),     32'(e_dig));
        expect_eq({tag, ".jumping"},     32'(jumping),     32'(e_jmp));
        expect_eq({tag, ".splat"},       32'(splat),       32'(e_spl));
        expect_eq({tag, ".alive_count"}, 32'(alive_count), 32'(alive));
        expect_eq({tag, ".all_dead"},    32'(all_dead),    32'(alive == 0));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    task automatic clear_inputs();
        bump_left = '0; bump_right = '0; small_bump_left = '0; small_bump_right = '0;
        dig = '0; ground = '1;
    endtask

    // Asserts reset away from any clock edge and checks its effect without a clock.
    task automatic async_reset(input string tag);
        #2 areset = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        expect_eq({tag, ".walk_left_ones"}, 32'(walk_left), 32'({N{1'b1}}));
        @(negedge clk);
        clear_inputs();
        areset = 1'b1;
    endtask

    initial begin
        model_reset();
        for (int i = 0; i < N; i++) low_run[i] = 0;
        #2;
        check_all("reset");
        @(negedge clk);
        areset = 1'b1;
        for (int c = 0; c < 10; c++) tick("idle");

        // Large bump reverses lane 0; trailing bumps then change nothing.
        bump_left[0] = 1'b1;
        tick("bump_rev");
        expect_eq("bump_rev.walk_right0", 32'(walk_right[0]), 32'd1);
        bump_left[0] = 1'b0; small_bump_right[0] = 1'b0;
        bump_left[0] = 1'b1;
        tick("trailing");
        bump_left[0] = 1'b0;
        expect_eq("trailing.walk_right0", 32'(walk_right[0]), 32'd1);

        // Jump on lane 1: airborne exactly JC cycles, then walk; then a jump ending over a hole.
        small_bump_left[1] = 1'b1;
        tick("jump1");
        small_bump_left[1] = 1'b0;
        expect_eq("jump1.jumping1", 32'(jumping[1]), 32'd1);
        tick("jump2");
        expect_eq("jump2.jumping1", 32'(jumping[1]), 32'd1);
        tick("jump_end");
        expect_eq("jump_end.walk_left1", 32'(walk_left[1]), 32'd1);
        small_bump_left[1] = 1'b1;
        tick("jump_b1");
        small_bump_left[1] = 1'b0;
        tick("jump_b2");
        ground[1] = 1'b0;
        tick("jump_fall");
        expect_eq("jump_fall.aah1", 32'(aah[1]), 32'd1);
        ground[1] = 1'b1;
        tick("jump_land");

        // Lane 2 boundary: FL low edges survive, FL+1 splat (when enabled).
        ground[2] = 1'b0;
        for (int c = 0; c < FL; c++) tick("fall_ok");
        ground[2] = 1'b1;
        tick("fall_ok_land");
        expect_eq("fall_ok_land.walk_left2", 32'(walk_left[2]), 32'd1);
        ground[2] = 1'b0;
        for (int c = 0; c < FL + 1; c++) tick("fall_long");
        ground[2] = 1'b1;
        tick("fall_long_land");
        expect_eq("fall_long_land.splat2", 32'(splat[2]), 32'(SPLAT_EN));
        for (int c = 0; c < 6; c++) begin
            bump_left[2] = $urandom_range(0, 1); bump_right[2] = $urandom_range(0, 1);
            small_bump_left[2] = $urandom_range(0, 1); dig[2] = $urandom_range(0, 1);
            tick("dead_hold");
        end
        clear_inputs();

        // Fresh run: lanes 0 and 3 fall 30 cycles and land together.
        async_reset("reset_mid");
        ground[0] = 1'b0; ground[3] = 1'b0;
        for (int c = 0; c < 30; c++) tick("twin_fall");
        ground = '1;
        tick("twin_land");
        expect_eq("twin_land.alive", 32'(alive_count), SPLAT_EN ? 32'd2 : 32'd4);

        // Reset in the middle of a fall and in the middle of a jump.
        ground[1] = 1'b0; small_bump_left[0] = 1'b1;
        for (int c = 0; c < 10; c++) tick("pre_abort");
        async_reset("abort");

        // Very long fall exercises counter saturation.
        ground[1] = 1'b0;
        for (int c = 0; c < 50; c++) tick("long_fall");
        ground[1] = 1'b1;
        tick("long_land");
        expect_eq("long_land.splat1", 32'(splat[1]), 32'(SPLAT_EN));

        // Randomized traffic with occasional mid-run resets.
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < N; i++) begin
                if (low_run[i] == 0 && $urandom_range(0, 11) == 0) low_run[i] = $urandom_range(1, 26);
                ground[i] = (low_run[i] == 0);
                if (low_run[i] > 0) low_run[i]--;
                bump_left[i]        = ($urandom_range(0, 5) == 0);
                bump_right[i]       = ($urandom_range(0, 5) == 0);
                small_bump_left[i]  = ($urandom_range(0, 4) == 0);
                small_bump_right[i] = ($urandom_range(0, 4) == 0);
                dig[i]              = ($urandom_range(0, 15) == 0);
            end
            tick("rand");
            if (c % 200 == 199) begin
                async_reset("rand_reset");
                for (int i = 0; i < N; i++) low_run[i] = 0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
